// File: rtl/aes_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_sched_pkg
// Description : Shared types and constants for the AES core scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_sched_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int CNT_W       = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/aes_core_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter; searches upward from ptr
//               with wrap-around and returns a one-hot grant plus its index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    input  logic            en,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_idx
);

    logic [ID_W:0] idx;
    logic          found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(N)) begin
                idx = idx - (ID_W+1)'(N);
            end
            if (en && !found && req[idx[ID_W-1:0]]) begin
                found                  = 1'b1;
                grant[idx[ID_W-1:0]]   = 1'b1;
                grant_idx              = idx[ID_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/aes_core_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : aes_core_scheduler
// Description : Time-shares one AES-128 core among N_REQ requesters with
//               round-robin grant and a fixed-latency completion timer.
//               Optional macro AES_SCHED_PERF_EN adds the ops_count output.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_core_scheduler
    import aes_sched_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int CORE_LATENCY = 11,
    parameter int ID_W         = $clog2(N_REQ)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [N_REQ*AES_BLOCK_W-1:0] req_plaintext,
    input  logic [N_REQ*AES_BLOCK_W-1:0] req_key,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [ID_W-1:0]              rsp_id,
    output logic [AES_BLOCK_W-1:0]       rsp_data,
    output logic                         core_start,
    output logic [AES_BLOCK_W-1:0]       core_plaintext,
    output logic [AES_BLOCK_W-1:0]       core_key,
    input  logic [AES_BLOCK_W-1:0]       core_ciphertext,
    output logic                         busy
`ifdef AES_SCHED_PERF_EN
    ,
    output logic [31:0]                  ops_count
`endif
);

    sched_state_t           state_q, state_d;
    logic [ID_W-1:0]        ptr_q, ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [AES_BLOCK_W-1:0] pt_q, pt_d;
    logic [AES_BLOCK_W-1:0] key_q, key_d;
    logic [AES_BLOCK_W-1:0] data_q, data_d;
    logic [ID_W-1:0]        id_q, id_d;
    logic                   core_start_q, core_start_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   busy_q, busy_d;

    logic [N_REQ-1:0]       grant;
    logic [ID_W-1:0]        grant_idx;
    logic [AES_BLOCK_W-1:0] sel_pt;
    logic [AES_BLOCK_W-1:0] sel_key;
    logic                   arb_en;

    // Gating with reset keeps req_ready low while reset is asserted.
    assign arb_en = (state_q == IDLE) && reset;

    rr_arbiter #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .en        (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        sel_pt  = '0;
        sel_key = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_pt  = req_plaintext[i*AES_BLOCK_W +: AES_BLOCK_W];
                sel_key = req_key[i*AES_BLOCK_W +: AES_BLOCK_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        pt_d    = pt_q;
        key_d   = key_q;
        data_d  = data_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    pt_d    = sel_pt;
                    key_d   = sel_key;
                    id_d    = grant_idx;
                    ptr_d   = (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_W'(CORE_LATENCY-1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    data_d  = core_ciphertext;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are registered so they follow the state they belong to.
        core_start_d = (state_d == ISSUE);
        rsp_valid_d  = (state_d == RESP);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            pt_q         <= '0;
            key_q        <= '0;
            data_q       <= '0;
            id_q         <= '0;
            core_start_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            pt_q         <= pt_d;
            key_q        <= key_d;
            data_q       <= data_d;
            id_q         <= id_d;
            core_start_q <= core_start_d;
            rsp_valid_q  <= rsp_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready      = grant;
    assign core_start     = core_start_q;
    assign core_plaintext = pt_q;
    assign core_key       = key_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_id         = id_q;
    assign rsp_data       = data_q;
    assign busy           = busy_q;

`ifdef AES_SCHED_PERF_EN
    logic [31:0] ops_q, ops_d;

    always_comb begin
        ops_d = ops_q;
        if (rsp_valid_q && rsp_ready && (ops_q != 32'hFFFF_FFFF)) begin
            ops_d = ops_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ops_q <= '0;
        end else begin
            ops_q <= ops_d;
        end
    end

    assign ops_count = ops_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_core_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_core_scheduler
// Description : Directed self-checking bench with a timed AES core model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_core_scheduler;

    localparam int N_REQ        = 4;
    localparam int CORE_LATENCY = 11;
    localparam int ID_W         = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [N_REQ-1:0]     req_valid = '0;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ*128-1:0] req_plaintext = '0;
    logic [N_REQ*128-1:0] req_key = '0;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b0;
    logic [ID_W-1:0]      rsp_id;
    logic [127:0]         rsp_data;
    logic                 core_start;
    logic [127:0]         core_plaintext;
    logic [127:0]         core_key;
    logic [127:0]         core_ciphertext;
    logic                 busy;
`ifdef AES_SCHED_PERF_EN
    logic [31:0]          ops_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    aes_core_scheduler #(
        .N_REQ        (N_REQ),
        .CORE_LATENCY (CORE_LATENCY),
        .ID_W         (ID_W)
    ) dut (
        .clk             (clk),
        .reset           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_plaintext   (req_plaintext),
        .req_key         (req_key),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_id          (rsp_id),
        .rsp_data        (rsp_data),
        .core_start      (core_start),
        .core_plaintext  (core_plaintext),
        .core_key        (core_key),
        .core_ciphertext (core_ciphertext),
        .busy            (busy)
`ifdef AES_SCHED_PERF_EN
        ,
        .ops_count       (ops_count)
`endif
    );

    always #5 clk = ~clk;

    // Known-answer vectors, otherwise a simple keyed mix.
    function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [127:0] key);
        if (pt == 128'h6bc1bee22e409f96e93d7e117393172a && key == 128'h2b7e151628aed2a6abf7158809cf4f3c)
            return 128'h3ad77bb40d7a3660a89ecaf32466ef97;
        if (pt == '0 && key == '0)
            return 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
        return pt ^ {key[63:0], key[127:64]};
    endfunction

    // Core model: result is only valid CORE_LATENCY cycles after the start cycle.
    logic [127:0] m_pt = '0, m_key = '0;
    int           m_age = 1000;
    always @(posedge clk) begin
        if (core_start) begin
            m_pt  <= core_plaintext;
            m_key <= core_key;
            m_age <= 1;
        end else if (m_age < 1000) begin
            m_age <= m_age + 1;
        end
    end
    assign core_ciphertext = (m_age == CORE_LATENCY) ? aes_model(m_pt, m_key) : 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic set_req(input int i, input logic [127:0] pt, input logic [127:0] key);
        req_plaintext[i*128 +: 128] = pt;
        req_key[i*128 +: 128]       = key;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Issue one request, wait for the response, stall, then complete it.
    task automatic serve(input int idx, input int stall, output int lat,
                         output logic [127:0] data, output logic [ID_W-1:0] id);
        logic [N_REQ-1:0] exp_ready;
        exp_ready      = '0;
        exp_ready[idx] = 1'b1;
        req_valid      = exp_ready;
        rsp_ready      = 1'b0;
        #1;
        check_eq("accept_ready", req_ready, exp_ready);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) req_valid = '0;
            if (rsp_valid) begin
                lat = n;
                break;
            end
        end
        data = rsp_data;
        id   = rsp_id;
        repeat (stall) @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("rsp_cleared", {rsp_valid, busy}, 2'b00);
    endtask

    initial begin
        int               lat;
        logic [127:0]     data;
        logic [ID_W-1:0]  id;
        int               grants[$];
        int               starts[$];
        logic [127:0]     h_data;
        logic [ID_W-1:0]  h_id;
        logic             stable;
        logic             seen;

        for (int i = 0; i < N_REQ; i++)
            set_req(i, {4{32'hA5A5_0000 + 32'(i)}}, {4{32'h0F0F_0000 + 32'(3*i)}});

        // Reset state, with all requests asserted.
        req_valid = '1;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_ready", req_ready, 4'b0000);
        check_eq("rst_ctrl", {core_start, rsp_valid, busy, rsp_id}, '0);
        check_eq("rst_core", {core_plaintext, core_key}, '0);
        check_eq("rst_data", rsp_data, '0);
        req_valid = '0;
        rst_n     = 1'b1;
        @(negedge clk);

        // 1: FIPS-197 vector from requester 0, latency check.
        set_req(0, 128'h6bc1bee22e409f96e93d7e117393172a, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        serve(0, 0, lat, data, id);
        check_eq("t1_latency", lat, 13);
        check_eq("t1_id", id, 0);
        check_eq("t1_data", data, 128'h3ad77bb40d7a3660a89ecaf32466ef97);

        // 2: all-zero vector from requester 2.
        set_req(2, '0, '0);
        serve(2, 0, lat, data, id);
        check_eq("t2_id", id, 2);
        check_eq("t2_data", data, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);

        // 3: all valid, rsp_ready tied high.
        for (int i = 0; i < N_REQ; i++)
            set_req(i, {4{32'h1234_0000 + 32'(i)}}, {4{32'h0055_AA00 + 32'(i)}});
        req_valid = '1;
        rsp_ready = 1'b1;
        apply_reset();
        for (int k = 0; k < 70; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            for (int i = 0; i < N_REQ; i++)
                if (req_ready[i]) grants.push_back(i);
            if (core_start) starts.push_back(k);
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        check_eq("t3_grant_cnt", (grants.size() >= 5), 1'b1);
        check_eq("t3_start_cnt", (starts.size() >= 5), 1'b1);
        if (grants.size() >= 5 && starts.size() >= 5) begin
            check_eq("t3_order", {grants[0][3:0], grants[1][3:0], grants[2][3:0], grants[3][3:0], grants[4][3:0]}, 20'h01230);
            for (int j = 1; j < 5; j++)
                check_eq("t3_spacing", starts[j] - starts[j-1], 14);
        end

        // 4: back-pressure for 20 cycles in RESP.
        apply_reset();
        req_valid = '1;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            seen = rsp_valid;
        end
        check_eq("t4_rsp_seen", seen, 1'b1);
        h_data = rsp_data;
        h_id   = rsp_id;
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!rsp_valid || rsp_data !== h_data || rsp_id !== h_id || req_ready != '0 || core_start)
                stable = 1'b0;
        end
        check_eq("t4_stable", stable, 1'b1);
        check_eq("t4_id", h_id, 0);
        check_eq("t4_data", h_data, aes_model({4{32'h1234_0000}}, {4{32'h0055_AA00}}));
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("t4_release", rsp_valid, 1'b0);

        // 5: reset during WAIT with the counter at 5.
        apply_reset();
        req_valid = 4'b0100;
        #1;
        check_eq("t5_ready", req_ready, 4'b0100);
        @(negedge clk);
        req_valid = '0;
        check_eq("t5_start", core_start, 1'b1);
        repeat (6) @(negedge clk);
        req_valid = '1;
        #2 rst_n = 1'b0;
        #1;
        check_eq("t5_abort_ctrl", {req_ready, core_start, rsp_valid, busy, rsp_id}, '0);
        check_eq("t5_abort_core", {core_plaintext, core_key}, '0);
        @(negedge clk);
        req_valid = '0;
        rst_n     = 1'b1;
        seen      = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid || core_start) seen = 1'b1;
        end
        check_eq("t5_no_rsp", seen, 1'b0);
        req_valid = '1;
        #1;
        check_eq("t5_ptr_reset", req_ready, 4'b0001);
        req_valid = '0;

`ifdef AES_SCHED_PERF_EN
        // 6: completion counter, stalled cycle does not count.
        apply_reset();
        check_eq("t6_ops_rst", ops_count, 0);
        serve(1, 1, lat, data, id);
        serve(2, 0, lat, data, id);
        serve(3, 2, lat, data, id);
        check_eq("t6_ops", ops_count, 3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/aes_core_scheduler.md
Name: aes_core_scheduler

Overview:
Shares one AES-128 encryption core among N_REQ requesters. Grants requesters round-robin and latches the winner's plaintext and key. Drives the core's one-cycle start pulse, waits a fixed core latency, then captures the ciphertext. Returns the result on one shared response channel, tagged with the requester id. Sits between client logic and aes_top; aes_top has no done flag, so completion is timed by this block.

Parameters:
N_REQ, 4, number of requesters (2..16)
CORE_LATENCY, 11, cycles from the core_start cycle to valid core_ciphertext (>=1)
ID_W, $clog2(N_REQ), width of rsp_id

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  per-requester accept, one-hot or zero
req_plaintext  in  N_REQ*128  flattened; requester i uses bits [128*i +: 128]
req_key  in  N_REQ*128  flattened, same packing
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  ID_W  index of the requester that owns the response
rsp_data  out  128  ciphertext
core_start  out  1  start pulse to the AES core
core_plaintext  out  128  to the AES core
core_key  out  128  to the AES core
core_ciphertext  in  128  from the AES core
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, rr pointer=0, counter=0.
  - All outputs 0: core_start, core_plaintext, core_key, rsp_valid, rsp_id, rsp_data, busy; req_ready is 0.
- FSM states are IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant = first i with req_valid[i]=1, searching from pointer upward and wrapping modulo N_REQ.
  - req_ready[grant]=1 combinationally; all other req_ready bits are 0.
  - On handshake: latch core_plaintext, core_key and rsp_id; set pointer=(grant+1) mod N_REQ; go to ISSUE.
  - With no valid request, stay in IDLE and leave the pointer unchanged.
- ISSUE:
  - core_start=1 for exactly this one cycle.
  - Load counter=CORE_LATENCY-1 and go to WAIT.
- WAIT:
  - core_start=0.
  - If counter==0, capture core_ciphertext into rsp_data and go to RESP; otherwise decrement the counter.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id held stable.
  - On rsp_ready=1, clear rsp_valid and go to IDLE.
- Timing:
  - Accept at cycle t, start at t+1, capture at the end of t+1+CORE_LATENCY, rsp_valid first high at t+2+CORE_LATENCY.
  - Minimum issue interval is CORE_LATENCY+3 cycles, because RESP always returns to IDLE before the next grant.
- core_plaintext and core_key stay stable from ISSUE until the next accept; they never change while the core is computing.
- req_ready is 0 in every non-IDLE state. A requester must hold req_valid and its data until it sees req_ready.
- Simultaneous requests resolve round-robin. The same requester cannot win twice in a row while another is valid.
- rsp_ready may already be high when rsp_valid rises. The response then completes in that cycle and IDLE follows on the next cycle.
- Reset asserted mid-operation aborts the in-flight operation with no response. The pointer returns to 0.

Optional Feature:
- Macro AES_SCHED_PERF_EN.
- Defined: adds output ops_count (32 bits), reset to 0.
  - Increments on each completed response handshake (rsp_valid and rsp_ready both 1).
  - Saturates at 32'hFFFF_FFFF.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package aes_sched_pkg holds:
  - AES_BLOCK_W=128
  - state enum sched_state_t {IDLE, ISSUE, WAIT, RESP}
  - CNT_W for the latency counter
- One sub-module, rr_arbiter (N parameter):
  - Inputs: req vector, pointer, enable.
  - Outputs: one-hot grant and its encoded index; purely combinational.
- FSM, latches and counter live in aes_core_scheduler.

Test Plan:
1. Single request with aes_top attached: requester 0, key 2b7e151628aed2a6abf7158809cf4f3c, pt 6bc1bee22e409f96e93d7e117393172a -> rsp_id=0, rsp_data=3ad77bb40d7a3660a89ecaf32466ef97; rsp_valid first high exactly 13 cycles after the accept edge.
2. All-zero key and all-zero pt from requester 2 -> rsp_data=66e94bd4ef8a2c3b884cfa59ca342b2e, rsp_id=2.
3. All four requesters held valid from reset release, rsp_ready tied 1 -> grant order 0,1,2,3,0; the core_start pulses are spaced exactly 14 cycles apart.
4. rsp_ready held low for 20 cycles in RESP -> rsp_valid, rsp_data and rsp_id stay stable; every req_ready stays 0; no extra core_start pulse.
5. Reset pulled low during WAIT with counter=5 -> all outputs 0 immediately; no response after release; the next grant starts from requester 0.
6. With AES_SCHED_PERF_EN defined, 3 completed responses -> ops_count=3; one rsp_valid cycle with rsp_ready=0 does not count.
